// File: rtl/vga_pkg.sv
// Shared constants, state encoding and address helper for the VGA scan-out block.
package vga_pkg;

  // Horizontal timing, pixel ticks
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = 800;

  // Vertical timing, lines
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = 525;

  // Framebuffer geometry
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = 19200;
  localparam int ADDR_W   = 15;
  localparam int COLOR_W  = 3;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fsm_state_e;

  // row*160 + col, built from two shifts so no multiplier is needed
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    logic [ADDR_W-1:0] r;
    r = {8'd0, row};
    fb_addr = (r << 7) + (r << 5) + {7'd0, col};
  endfunction

endpackage

// File: rtl/vga_framebuffer.sv
// 19200x3 simple dual-port framebuffer: one write port, one synchronous read port.
module vga_framebuffer
  import vga_pkg::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [COLOR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [COLOR_W-1:0] rdata_o
);

  logic [COLOR_W-1:0] mem_q [0:FB_DEPTH-1];
  logic [COLOR_W-1:0] rdata_q;

  // Write port plus registered read; a same-address read returns the old word
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_scanout.sv
// 160x120 framebuffer with post-reset clear, plot write port and 640x480 VGA scan-out.
module vga_scanout #(
  parameter logic [2:0] BACKGROUND = 3'b000,
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] color,
  input  logic       plot,
  output logic       ready,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);
  import vga_pkg::*;

  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] CLR_LAST = 15'(FB_DEPTH - 1);

  logic                pix_en_q;
  logic [9:0]          hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic                vis_s, hs_raw_s, vs_raw_s;
  logic [ADDR_W-1:0]   scan_addr_s, rd_addr_q;
  logic                vis1_q, hs1_q, vs1_q;
  logic [COLOR_W-1:0]  rgb_q, rd_data_s;
  logic                hs_q, vs_q, blank_n_q;
  fsm_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                ready_q;
  logic                plot_ok_s, we_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [COLOR_W-1:0]  wdata_s;

  // Pixel tick: CLOCK_50 divided by two, also driven out as VGA_CLK
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) pix_en_q <= 1'b0;
    else         pix_en_q <= ~pix_en_q;
  end

  // Next raster position; vcnt steps when hcnt wraps
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = 10'd0;
        if (vcnt_q == V_LAST) vcnt_d = 10'd0;
        else                  vcnt_d = vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Raster position registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hcnt_q <= 10'd0;
      vcnt_q <= 10'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Raw sync/blank windows and the framebuffer address of the current position
  always_comb begin
    vis_s    = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    hs_raw_s = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_raw_s = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    if (vis_s) scan_addr_s = fb_addr(vcnt_q[8:2], hcnt_q[9:2]);
    else       scan_addr_s = 15'd0;
  end

  // Scan stage 1: read address and raw flags
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rd_addr_q <= 15'd0;
      vis1_q    <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
    end else if (pix_en_q) begin
      rd_addr_q <= scan_addr_s;
      vis1_q    <= vis_s;
      hs1_q     <= hs_raw_s;
      vs1_q     <= vs_raw_s;
    end
  end

  // Scan stage 2: RAM data and delayed flags onto the pins, black outside the visible area
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rgb_q     <= 3'b000;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else if (pix_en_q) begin
      rgb_q     <= vis1_q ? rd_data_s : 3'b000;
      hs_q      <= hs1_q;
      vs_q      <= vs1_q;
      blank_n_q <= vis1_q;
    end
  end

  // Write FSM state, clear pointer and ready flag
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= CLEAR;
      clr_addr_q <= 15'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= (state_q == RUN);
    end
  end

  // Write FSM next state: sweep the whole buffer once, then stay in RUN
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        if (clr_addr_q == CLR_LAST) state_d = RUN;
        else                        clr_addr_d = clr_addr_q + 15'd1;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Write FSM outputs: clear writes background, RUN writes in-range plots
  always_comb begin
    we_s      = 1'b0;
    waddr_s   = 15'd0;
    wdata_s   = 3'b000;
    plot_ok_s = plot && (x < 8'(FB_W)) && (y < 7'(FB_H));
    case (state_q)
      CLEAR: begin
        we_s    = 1'b1;
        waddr_s = clr_addr_q;
        wdata_s = BACKGROUND;
      end
      RUN: begin
        if (plot_ok_s) begin
          we_s    = 1'b1;
          waddr_s = fb_addr(y, x);
          wdata_s = color;
        end else begin
          we_s    = 1'b0;
        end
      end
      default: we_s = 1'b0;
    endcase
  end

  vga_framebuffer u_fb (
    .clk_i   (CLOCK_50),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .raddr_i (rd_addr_q),
    .rdata_o (rd_data_s)
  );

  assign ready       = ready_q;
  assign VGA_R       = {8{rgb_q[2]}};
  assign VGA_G       = {8{rgb_q[1]}};
  assign VGA_B       = {8{rgb_q[0]}};
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pix_en_q;

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display end of the pixel-plot interface driven by the drawing FSMs (`x`/`y`/`color`/`plot`).
- Holds a 160x120, 3-bit framebuffer. Clears it to a background colour after reset.
- Continuously scans the framebuffer out as 640x480@60 Hz VGA, with each stored pixel replicated 4x4.
- Sits beside the drawing logic in `top_VGA`; owns all `VGA_*` pins.

Parameters:
- BACKGROUND, 3'b000, colour written to every location during the post-reset clear.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel ticks (total 800).
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525).

Ports:
- CLOCK_50  in  1  50 MHz system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- x  in  8  write column, 0..159.
- y  in  7  write row, 0..119.
- color  in  3  write colour {R,G,B}.
- plot  in  1  write strobe, one write per asserted cycle.
- ready  out  1  high when the clear is finished and plot writes are accepted.
- VGA_R, VGA_G, VGA_B  out  8 each  colour bit replicated to 8 bits (8'hFF / 8'h00).
- VGA_HS, VGA_VS  out  1  active-low syncs.
- VGA_BLANK_N  out  1  high during visible area.
- VGA_SYNC_N  out  1  tied 0.
- VGA_CLK  out  1  25 MHz pixel clock.

Behaviour:
- Reset values (async, resetn=0):
  - `pix_en`=0, VGA_CLK=0.
  - hcnt=0, vcnt=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0.
  - ready=0, state=CLEAR, clr_addr=0.
- Pixel enable:
  - `pix_en` toggles every CLOCK_50 cycle; VGA_CLK mirrors it.
  - Counters and the scan pipeline advance only on cycles where `pix_en`=1.
- Counters:
  - hcnt counts 0..799, wrapping to 0.
  - vcnt increments when hcnt wraps; counts 0..524, wrapping to 0.
- Sync and blank windows (raw, before pipeline delay):
  - HS low for hcnt 656..751.
  - VS low for vcnt 490..491.
  - visible when hcnt<640 and vcnt<480.
- Scan pipeline (2 pix_en ticks):
  - S1 registers rd_addr = (vcnt>>2)*160 + (hcnt>>2), plus the raw vis/HS/VS.
  - S2 registers the RAM read data and the delayed flags onto the outputs.
  - RGB is forced to 0 whenever the delayed vis=0.
- Outputs lag the counters by exactly 2 pixel ticks.
- Address arithmetic: 15-bit. Multiply by 160 is implemented as (row<<7)+(row<<5).
- Write/clear FSM, state CLEAR:
  - Writes BACKGROUND to clr_addr every CLOCK_50 cycle; clr_addr increments.
  - At clr_addr=19199 performs the final write, then goes to RUN; ready=1 from the next cycle.
  - `plot` is ignored in CLEAR. Scan-out runs during the clear and shows mixed content.
- Write/clear FSM, state RUN:
  - plot=1 with x<160 and y<120 writes `color` to y*160+x that cycle.
  - Out-of-range coordinates are ignored silently.
  - Consecutive plot cycles each write; there is no backpressure.
- Read/write collision on the same address in the same cycle: read returns the old data (read-before-write).
- Reset mid-operation: everything restarts immediately. The clear restarts from address 0, and the RAM content is rewritten by the clear.

Decomposition:
- Package `vga_pkg`:
  - timing constants (H_*, V_*, totals 800/525)
  - FB_W=160, FB_H=120, FB_DEPTH=19200, ADDR_W=15, COLOR_W=3
  - FSM state enum {CLEAR, RUN}
- One sub-module `vga_framebuffer`:
  - simple dual-port RAM, 19200x3
  - one write port and one synchronous read port, single clock
  - no reset

Test Plan:
- Hold resetn=0 for 2 cycles, then release:
  - all outputs at their reset values while resetn=0
  - ready rises exactly 19201 CLOCK_50 cycles after release
  - with BACKGROUND=3'b101, reading any location gives 101
- During CLEAR, plot=1, x=5, y=5, color=3'b010:
  - location 805 still holds BACKGROUND after ready rises.
- After ready, plot x=0, y=0, color=3'b100 for one cycle:
  - at the first visible pixel of the frame, RGB=FF/00/00 for 4 pixel ticks on lines 0..3
  - RGB reverts to background at pixel 4.
- Plot x=200, y=10 and x=10, y=130:
  - no RAM write occurs; a frame dump matches the pre-write frame.
- Frame timing:
  - count 800 pixel ticks per line, HS low for 96 of them
  - 525 lines per frame, VS low for 2 lines
  - BLANK_N high for 640x480 ticks
  - HS falling edge exactly 2 ticks after hcnt=656
- Assert resetn=0 mid-frame during RUN:
  - outputs return to reset values asynchronously, ready=0
  - after release, the clear repeats and the earlier plot at (0,0) is erased.
